decode: RTL and testbench

DECODE -- requirements
Module: decode

---
 rtl/core_pkg.sv | 57 +++++
 rtl/decode_if.sv | 52 +++++
 rtl/decode_imm.sv | 43 ++++
 rtl/decode.sv | 204 ++++++++++++++++++++
 tb/tb_decode.sv | 352 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// Shared core definitions: execution unit codes, exception causes, RV32I opcodes
// and the decoded micro-op record passed from decode to rename.
package core_pkg;

  typedef enum logic [2:0] {
    UNIT_ALU    = 3'd0,
    UNIT_BR     = 3'd1,
    UNIT_LD     = 3'd2,
    UNIT_ST     = 3'd3,
    UNIT_MULDIV = 3'd4,
    UNIT_SYS    = 3'd5
  } unit_e;

  typedef enum logic [1:0] {
    EC_NONE    = 2'd0,
    EC_IFAULT  = 2'd1,
    EC_ILLEGAL = 2'd2
  } ecause_e;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  // PC-relative and fence ops have no funct3; they use codes above 7 in their unit.
  localparam logic [3:0] FUNC_JAL   = 4'd8;
  localparam logic [3:0] FUNC_JALR  = 4'd9;
  localparam logic [3:0] FUNC_AUIPC = 4'd10;
  localparam logic [3:0] FUNC_FENCE = 4'd8;

  typedef struct packed {
    logic [29:0] addr;
    unit_e       unit;
    logic [3:0]  func;
    logic [4:0]  rsrc1;
    logic [4:0]  rsrc2;
    logic [4:0]  rdst;
    logic        rdst_en;
    logic [31:0] imm;
    logic        imm_en;
    logic        exc;
    ecause_e     ecause;
    logic [13:0] bptag;
    logic        bptaken;
  } uop_t;

endpackage

// File: rtl/decode_if.sv
// Fetch->decode and decode->rename handshake bundles.
interface fetch_de_if;
  logic        fetch_de_valid;
  logic        fetch_de_error;
  logic [29:0] fetch_de_addr;
  logic [31:0] fetch_de_insn;
  logic [13:0] fetch_de_bptag;
  logic        fetch_de_bptaken;
  logic        decode_stall;

  modport master (
    output fetch_de_valid, fetch_de_error, fetch_de_addr, fetch_de_insn,
           fetch_de_bptag, fetch_de_bptaken,
    input  decode_stall
  );
  modport slave (
    input  fetch_de_valid, fetch_de_error, fetch_de_addr, fetch_de_insn,
           fetch_de_bptag, fetch_de_bptaken,
    output decode_stall
  );
endinterface

interface decode_uop_if;
  logic        decode_valid;
  logic [29:0] decode_addr;
  logic [2:0]  decode_unit;
  logic [3:0]  decode_func;
  logic [4:0]  decode_rsrc1;
  logic [4:0]  decode_rsrc2;
  logic [4:0]  decode_rdst;
  logic        decode_rdst_en;
  logic [31:0] decode_imm;
  logic        decode_imm_en;
  logic        decode_exc;
  logic [1:0]  decode_ecause;
  logic [13:0] decode_bptag;
  logic        decode_bptaken;
  logic        rename_stall;

  modport master (
    output decode_valid, decode_addr, decode_unit, decode_func, decode_rsrc1,
           decode_rsrc2, decode_rdst, decode_rdst_en, decode_imm, decode_imm_en,
           decode_exc, decode_ecause, decode_bptag, decode_bptaken,
    input  rename_stall
  );
  modport slave (
    input  decode_valid, decode_addr, decode_unit, decode_func, decode_rsrc1,
           decode_rsrc2, decode_rdst, decode_rdst_en, decode_imm, decode_imm_en,
           decode_exc, decode_ecause, decode_bptag, decode_bptaken,
    output rename_stall
  );
endinterface

// File: rtl/decode_imm.sv
// Combinational RV32I immediate extraction; selects the I/S/B/U/J layout from the opcode.
module decode_imm
  import core_pkg::*;
(
  input  logic [31:0] insn_i,
  output logic [31:0] imm_o,
  output logic        imm_en_o
);

  always_comb begin
    imm_o    = '0;
    imm_en_o = 1'b0;
    case (insn_i[6:0])
      OPC_LOAD, OPC_OPIMM, OPC_JALR, OPC_FENCE, OPC_SYSTEM: begin
        imm_o    = {{20{insn_i[31]}}, insn_i[31:20]};
        imm_en_o = 1'b1;
      end
      OPC_STORE: begin
        imm_o    = {{20{insn_i[31]}}, insn_i[31:25], insn_i[11:7]};
        imm_en_o = 1'b1;
      end
      OPC_BRANCH: begin
        imm_o    = {{19{insn_i[31]}}, insn_i[31], insn_i[7], insn_i[30:25],
                    insn_i[11:8], 1'b0};
        imm_en_o = 1'b1;
      end
      OPC_LUI, OPC_AUIPC: begin
        imm_o    = {insn_i[31:12], 12'b0};
        imm_en_o = 1'b1;
      end
      OPC_JAL: begin
        imm_o    = {{11{insn_i[31]}}, insn_i[31], insn_i[19:12], insn_i[20],
                    insn_i[30:21], 1'b0};
        imm_en_o = 1'b1;
      end
      default: begin
        imm_o    = '0;
        imm_en_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/decode.sv
// Single-stage RV32I decoder with a one-entry output register toward rename.
// Define DECODE_MULDIV_EN to accept RV32M; otherwise those encodings are illegal.
module decode
  import core_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          rob_flush,
  fetch_de_if.slave     fe,
  decode_uop_if.master  rn
);

  logic [31:0] insn;
  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm;
  logic        imm_en;

  assign insn   = fe.fetch_de_insn;
  assign opcode = insn[6:0];
  assign rd     = insn[11:7];
  assign f3     = insn[14:12];
  assign rs1    = insn[19:15];
  assign rs2    = insn[24:20];
  assign f7     = insn[31:25];

  decode_imm u_imm (
    .insn_i   (insn),
    .imm_o    (imm),
    .imm_en_o (imm_en)
  );

  unit_e      unit;
  logic [3:0] func;
  logic       illegal, use_rs1, use_rs2, has_rd;

  always_comb begin
    unit    = UNIT_ALU;
    func    = {1'b0, f3};
    illegal = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    has_rd  = 1'b0;
    case (opcode)
      OPC_LUI: begin
        func   = '0;
        has_rd = 1'b1;
      end
      OPC_AUIPC: begin
        unit   = UNIT_BR;
        func   = FUNC_AUIPC;
        has_rd = 1'b1;
      end
      OPC_JAL: begin
        unit   = UNIT_BR;
        func   = FUNC_JAL;
        has_rd = 1'b1;
      end
      OPC_JALR: begin
        unit    = UNIT_BR;
        func    = FUNC_JALR;
        use_rs1 = 1'b1;
        has_rd  = 1'b1;
        illegal = (f3 != 3'b000);
      end
      OPC_BRANCH: begin
        unit    = UNIT_BR;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        illegal = (f3[2:1] == 2'b01);
      end
      OPC_LOAD: begin
        unit    = UNIT_LD;
        use_rs1 = 1'b1;
        has_rd  = 1'b1;
        illegal = (f3 == 3'b011) || (f3[2:1] == 2'b11);
      end
      OPC_STORE: begin
        unit    = UNIT_ST;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        illegal = f3[2] || (f3[1:0] == 2'b11);
      end
      OPC_OPIMM: begin
        use_rs1 = 1'b1;
        has_rd  = 1'b1;
        if (f3 == 3'b001) begin
          illegal = (f7 != 7'b0);
        end else if (f3 == 3'b101) begin
          illegal = (f7 != 7'b0) && (f7 != F7_ALT);
          func    = {insn[30], f3};
        end
      end
      OPC_OP: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        has_rd  = 1'b1;
        if (f7 == F7_ALT) begin
          func    = {1'b1, f3};
          illegal = !((f3 == 3'b000) || (f3 == 3'b101));
        end else if (f7 == F7_MULDIV) begin
`ifdef DECODE_MULDIV_EN
          unit = UNIT_MULDIV;
`else
          illegal = 1'b1;
`endif
        end else begin
          illegal = (f7 != 7'b0);
        end
      end
      OPC_FENCE: begin
        unit    = UNIT_SYS;
        func    = FUNC_FENCE;
        use_rs1 = 1'b1;
        has_rd  = 1'b1;
        illegal = (f3 != 3'b000);
      end
      OPC_SYSTEM: begin
        // Only ECALL/EBREAK: everything but imm[0] must be zero.
        unit    = UNIT_SYS;
        func    = '0;
        illegal = (insn[31:21] != '0) || (insn[19:7] != '0);
      end
      default: illegal = 1'b1;
    endcase
  end

  uop_t dec;

  always_comb begin
    dec       = '0;
    dec.addr  = fe.fetch_de_addr;
    dec.bptag = fe.fetch_de_bptag;
    if (fe.fetch_de_error) begin
      dec.unit   = UNIT_SYS;
      dec.exc    = 1'b1;
      dec.ecause = EC_IFAULT;
    end else if (illegal) begin
      dec.unit   = UNIT_SYS;
      dec.exc    = 1'b1;
      dec.ecause = EC_ILLEGAL;
    end else begin
      dec.unit    = unit;
      dec.func    = func;
      dec.rsrc1   = use_rs1 ? rs1 : '0;
      dec.rsrc2   = use_rs2 ? rs2 : '0;
      dec.rdst    = has_rd ? rd : '0;
      dec.rdst_en = has_rd && (rd != 5'd0);
      dec.imm     = imm;
      dec.imm_en  = imm_en;
      dec.bptaken = fe.fetch_de_bptaken && (unit == UNIT_BR);
    end
  end

  logic valid_q, valid_d;
  uop_t uop_q, uop_d;
  logic out_valid, accept;

  // Gating with rst drops a held uop immediately, before the registers clear.
  assign out_valid       = valid_q && !rst;
  assign fe.decode_stall = out_valid && rn.rename_stall;
  assign accept          = fe.fetch_de_valid && !fe.decode_stall && !rob_flush;

  always_comb begin
    valid_d = valid_q;
    uop_d   = uop_q;
    if (rob_flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
      uop_d   = dec;
    end else if (!rn.rename_stall) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      uop_q   <= '0;
    end else begin
      valid_q <= valid_d;
      uop_q   <= uop_d;
    end
  end

  assign rn.decode_valid   = out_valid;
  assign rn.decode_addr    = uop_q.addr;
  assign rn.decode_unit    = uop_q.unit;
  assign rn.decode_func    = uop_q.func;
  assign rn.decode_rsrc1   = uop_q.rsrc1;
  assign rn.decode_rsrc2   = uop_q.rsrc2;
  assign rn.decode_rdst    = uop_q.rdst;
  assign rn.decode_rdst_en = uop_q.rdst_en;
  assign rn.decode_imm     = uop_q.imm;
  assign rn.decode_imm_en  = uop_q.imm_en;
  assign rn.decode_exc     = uop_q.exc;
  assign rn.decode_ecause  = uop_q.ecause;
  assign rn.decode_bptag   = uop_q.bptag;
  assign rn.decode_bptaken = uop_q.bptaken;

endmodule

// File: tb/tb_decode.sv
// Scoreboard bench for decode: a reference decoder computes each accepted uop,
// and a negedge monitor checks valid/stall and the presented uop against the queue.
module tb_decode;

  typedef struct packed {
    logic [29:0] addr;
    logic [2:0]  unit;
    logic [3:0]  func;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rd_en;
    logic [31:0] imm;
    logic        imm_en;
    logic        exc;
    logic [1:0]  ec;
    logic [13:0] tag;
    logic        bpt;
  } uop_x;

  localparam int unsigned FR = 0, FI = 1, FS = 2, FB = 3, FU = 4, FJ = 5;

  logic clk = 1'b0;
  logic rst;
  logic rob_flush;
  always #5 clk = ~clk;

  fetch_de_if   fe ();
  decode_uop_if rn ();

  decode dut (
    .clk       (clk),
    .rst       (rst),
    .rob_flush (rob_flush),
    .fe        (fe),
    .rn        (rn)
  );

  int unsigned n_checks = 0;
  int unsigned n_err    = 0;
  uop_x        q[$];
  uop_x        pend;
  bit          pend_v = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic uop_x model(input logic [31:0] w, input logic err, input logic [29:0] a,
                                 input logic [13:0] tag, input logic bt);
    uop_x        e;
    int unsigned fmt;
    bit          legal;
    logic [2:0]  f3;
    logic [6:0]  f7;
    f3 = w[14:12];
    f7 = w[31:25];
    e = '0;
    e.addr = a;
    e.tag  = tag;
    legal = 1;
    fmt = FR;
    e.func = {1'b0, f3};
    case (w[6:0])
      7'h37: begin fmt = FU; e.func = 0; end
      7'h17: begin fmt = FU; e.unit = 1; e.func = 10; end
      7'h6F: begin fmt = FJ; e.unit = 1; e.func = 8; end
      7'h67: begin fmt = FI; e.unit = 1; e.func = 9; legal = (f3 == 0); end
      7'h63: begin fmt = FB; e.unit = 1; legal = (f3 != 2 && f3 != 3); end
      7'h03: begin fmt = FI; e.unit = 2; legal = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}); end
      7'h23: begin fmt = FS; e.unit = 3; legal = (f3 <= 2); end
      7'h13: begin
        fmt = FI;
        if (f3 == 1) legal = (f7 == 0);
        if (f3 == 5) begin
          legal  = (f7 == 0 || f7 == 7'h20);
          e.func = (f7 == 7'h20) ? 4'd13 : 4'd5;
        end
      end
      7'h33: begin
        fmt = FR;
        if (f7 == 7'h20) begin
          legal  = (f3 == 0 || f3 == 5);
          e.func = 4'd8 + {1'b0, f3};
        end else if (f7 == 7'h01) begin
`ifdef DECODE_MULDIV_EN
          e.unit = 4;
`else
          legal = 0;
`endif
        end else legal = (f7 == 0);
      end
      7'h0F: begin fmt = FI; e.unit = 5; e.func = 8; legal = (f3 == 0); end
      7'h73: begin fmt = FI; e.unit = 5; e.func = 0; legal = (w == 32'h73 || w == 32'h0010_0073); end
      default: legal = 0;
    endcase
    if (err || !legal) begin
      e = '0;
      e.addr = a;
      e.tag  = tag;
      e.unit = 5;
      e.exc  = 1;
      e.ec   = err ? 2'd1 : 2'd2;
      return e;
    end
    if (fmt inside {FR, FI, FS, FB}) e.rs1 = w[19:15];
    if (fmt inside {FR, FS, FB})     e.rs2 = w[24:20];
    if (fmt inside {FR, FI, FU, FJ}) begin
      e.rd    = w[11:7];
      e.rd_en = (w[11:7] != 0);
    end
    case (fmt)
      FI: e.imm = 32'(w[31:20]) - (w[31] ? 32'd4096 : 32'd0);
      FS: e.imm = 32'({w[31:25], w[11:7]}) - (w[31] ? 32'd4096 : 32'd0);
      FB: e.imm = 32'(w[7]) * 2048 + 32'(w[30:25]) * 32 + 32'(w[11:8]) * 2
                  - (w[31] ? 32'd4096 : 32'd0);
      FU: e.imm = 32'(w[31:12]) * 4096;
      FJ: e.imm = 32'(w[19:12]) * 4096 + 32'(w[20]) * 2048 + 32'(w[30:21]) * 2
                  - (w[31] ? 32'h0010_0000 : 32'd0);
      default: e.imm = 0;
    endcase
    e.imm_en = (fmt != FR);
    e.bpt    = bt && (e.unit == 1);
    return e;
  endfunction

  function automatic uop_x observe();
    uop_x o;
    o.addr   = rn.decode_addr;
    o.unit   = rn.decode_unit;
    o.func   = rn.decode_func;
    o.rs1    = rn.decode_rsrc1;
    o.rs2    = rn.decode_rsrc2;
    o.rd     = rn.decode_rdst;
    o.rd_en  = rn.decode_rdst_en;
    o.imm    = rn.decode_imm;
    o.imm_en = rn.decode_imm_en;
    o.exc    = rn.decode_exc;
    o.ec     = rn.decode_ecause;
    o.tag    = rn.decode_bptag;
    o.bpt    = rn.decode_bptaken;
    return o;
  endfunction

  // Monitor: the queue front is the uop the DUT must be presenting.
  always @(negedge clk) begin
    uop_x got;
    if (rst) begin
      chk("reset_valid", 128'(rn.decode_valid), 128'(0));
      chk("reset_stall", 128'(fe.decode_stall), 128'(0));
    end else begin
      chk("valid", 128'(rn.decode_valid), 128'(q.size() != 0));
      chk("stall", 128'(fe.decode_stall), 128'((q.size() != 0) && rn.rename_stall));
      if (rn.decode_valid && q.size() != 0) begin
        got = observe();
        chk("uop", 128'(got), 128'(q[0]));
        if (!rn.rename_stall || rob_flush) void'(q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (pend_v) begin
      q.push_back(pend);
      pend_v = 0;
    end
  endtask

  task automatic set_in(input logic v, input logic [31:0] w, input logic err,
                        input logic [29:0] a, input logic [13:0] tag, input logic bt,
                        input logic rs, input logic fl, output logic acc);
    fe.fetch_de_valid   = v;
    fe.fetch_de_insn    = w;
    fe.fetch_de_error   = err;
    fe.fetch_de_addr    = a;
    fe.fetch_de_bptag   = tag;
    fe.fetch_de_bptaken = bt;
    rn.rename_stall     = rs;
    rob_flush           = fl;
    acc = v && !rst && !fl && !((q.size() != 0) && rs);
    if (acc) begin
      pend   = model(w, err, a, tag, bt);
      pend_v = 1;
    end
  endtask

  task automatic idle(input logic rs);
    logic acc;
    set_in(0, 32'h0, 0, 30'h0, 14'h0, 0, rs, 0, acc);
  endtask

  task automatic issue(input logic [31:0] w, input logic err, input logic bt);
    logic acc;
    set_in(1, w, err, 30'h0123456, 14'h2A5, bt, 0, 0, acc);
    chk("issue_accept", 128'(acc), 128'(1));
    step();
    idle(0);
    #2;
  endtask

  function automatic logic [31:0] rand_insn();
    logic [6:0]  ops [11];
    logic [31:0] w;
    ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};
    w = $urandom;
    case ($urandom_range(0, 9))
      0: return w;
      1: return {7'b0000001, w[24:7], 7'h33};
      2: return {w[31:25] & 7'b0100000, w[24:7], 7'h33};
      3: return $urandom_range(0, 1) ? 32'h73 : 32'h0010_0073;
      default: return {w[31:7], ops[$urandom_range(0, 10)]};
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic        acc, hold, v, err, bt, rs, fl;
    logic [31:0] w;
    logic [29:0] a;
    logic [13:0] tag;

    rst = 1;
    idle(0);
    repeat (3) step();
    chk("reset_uop_zero", 128'(observe()), 128'(0));
    rst = 0;
    idle(0);
    step();

    // addi x1,x0,5
    issue(32'h0050_0093, 0, 0);
    chk("addi_valid", 128'(rn.decode_valid), 128'(1));
    chk("addi_unit", 128'(rn.decode_unit), 128'(0));
    chk("addi_rdst", 128'({rn.decode_rdst, rn.decode_rdst_en}), 128'({5'd1, 1'b1}));
    chk("addi_rsrc1", 128'(rn.decode_rsrc1), 128'(0));
    chk("addi_imm", 128'({rn.decode_imm, rn.decode_imm_en}), 128'({32'd5, 1'b1}));
    step();

    // held uop under 3 cycles of rename_stall with a new insn waiting
    issue(32'h0070_0113, 0, 0);
    repeat (3) begin
      set_in(1, 32'h0090_0193, 0, 30'h77, 14'h11, 0, 1, 0, acc);
      #2;
      chk("stall_out", 128'(fe.decode_stall), 128'(1));
      chk("stall_hold", 128'({rn.decode_valid, rn.decode_rdst, rn.decode_imm}),
          128'({1'b1, 5'd2, 32'd7}));
      step();
    end
    set_in(1, 32'h0090_0193, 0, 30'h77, 14'h11, 0, 0, 0, acc);
    chk("stall_release_accept", 128'(acc), 128'(1));
    step();
    idle(0);
    #2;
    chk("stall_new_uop", 128'({rn.decode_valid, rn.decode_rdst, rn.decode_imm}),
        128'({1'b1, 5'd3, 32'd9}));
    step();

    // flush while stalled, with a new insn offered in the same cycle
    issue(32'h00B0_0113, 0, 0);
    set_in(1, 32'h00D0_0213, 0, 30'h5, 14'h5, 0, 1, 1, acc);
    step();
    idle(0);
    #2;
    chk("flush_valid", 128'(rn.decode_valid), 128'(0));
    step();
    idle(0);
    #2;
    chk("flush_no_replay", 128'(rn.decode_valid), 128'(0));
    step();

    // fetch fault
    issue(32'hFFFF_FFFF, 1, 0);
    chk("ifault", 128'({rn.decode_exc, rn.decode_ecause, rn.decode_rdst_en, rn.decode_unit}),
        128'({1'b1, 2'd1, 1'b0, 3'd5}));
    step();

    // mul x0,x1,x2
    issue(32'h0220_8033, 0, 0);
`ifdef DECODE_MULDIV_EN
    chk("mul", 128'({rn.decode_exc, rn.decode_unit, rn.decode_rdst_en}), 128'({1'b0, 3'd4, 1'b0}));
`else
    chk("mul", 128'({rn.decode_exc, rn.decode_ecause, rn.decode_unit}), 128'({1'b1, 2'd2, 3'd5}));
`endif
    step();

    // beq x0,x0,-4 predicted taken; same prediction on addi is dropped
    issue(32'hFE00_0EE3, 0, 1);
    chk("beq", 128'({rn.decode_unit, rn.decode_imm, rn.decode_bptaken}),
        128'({3'd1, 32'hFFFF_FFFC, 1'b1}));
    step();
    issue(32'h0050_0093, 0, 1);
    chk("addi_bptaken", 128'(rn.decode_bptaken), 128'(0));
    step();

    // reset asserted while a uop is held under stall
    issue(32'h0010_0293, 0, 0);
    idle(1);
    #2;
    chk("pre_reset_stall", 128'(fe.decode_stall), 128'(1));
    step();
    rst = 1;
    q.delete();
    pend_v = 0;
    idle(1);
    #2;
    chk("reset_drop", 128'({rn.decode_valid, fe.decode_stall}), 128'(0));
    step();
    rst = 0;
    idle(1);
    #2;
    chk("after_reset_valid", 128'(rn.decode_valid), 128'(0));
    step();

    // randomized traffic; fetch holds an offer that was stalled out
    hold = 0;
    v = 0; w = 0; err = 0; a = 0; tag = 0; bt = 0;
    repeat (3000) begin
      rs = ($urandom_range(0, 99) < 30);
      fl = ($urandom_range(0, 99) < 4);
      if (!hold) begin
        v   = ($urandom_range(0, 99) < 75);
        w   = rand_insn();
        err = ($urandom_range(0, 19) == 0);
        a   = 30'($urandom);
        tag = 14'($urandom);
        bt  = 1'($urandom);
      end
      set_in(v, w, err, a, tag, bt, rs, fl, acc);
      hold = v && !acc && !fl;
      step();
    end

    idle(0);
    repeat (3) step();
    chk("drain_empty", 128'(q.size()), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
